// File: rtl/serial_word_packer_pkg.sv
// rtl/serial_word_packer_pkg.sv - types and helpers shared by the serial word packer
//
// Purpose: output holding register state encoding and the mapping from
//          "k-th accepted bit of a word" to its position in the parallel word.
// Ports:   none (package).

package serial_word_packer_pkg;

  // Output holding register occupancy; FULL is what the consumer sees as word_valid.
  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_FULL  = 1'b1
  } out_state_e;

  // Word index taken by accepted bit k (0-based from word start) in an f-bit word.
  // k is always < f, so the MSB-first subtraction cannot wrap.
  function automatic logic [31:0] slot_of(input logic [31:0] k,
                                          input logic [31:0] f,
                                          input logic        msb_first);
    return msb_first ? (f - 32'd1 - k) : k;
  endfunction

endpackage

// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - serial-to-parallel word assembler with one-deep output register
//
// Purpose: accepts one qualified bit per clock, gathers F bits into a word and
//          presents it on a valid/ready output. Words completed while the
//          output register is still occupied and not draining are dropped and
//          flagged in a sticky overflow bit.
// Parameters:
//   F          word width in bits (>= 1)
//   MSB_FIRST  0: first bit -> word_out[0]; 1: first bit -> word_out[F-1]
// Ports:
//   clk         in   sole clock, rising edge
//   rstn        in   asynchronous active-low reset
//   bit_in      in   serial data bit
//   bit_valid   in   bit_in accepted on this edge (no backpressure)
//   word_out    out  assembled word, stable while word_valid is high
//   word_valid  out  output register holds an undelivered word
//   word_ready  in   consumer takes word_out when word_valid && word_ready
//   overflow    out  sticky: a completed word was dropped
//   clear_ovf   in   synchronous clear of overflow (loses to a same-edge drop)
//   fill        out  bits held in the partial word (0..F-1)

module serial_word_packer
  import serial_word_packer_pkg::*;
#(
  parameter  int unsigned F         = 3,
  parameter  int unsigned MSB_FIRST = 0,
  localparam int unsigned FILL_W    = $clog2(F + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              bit_in,
  input  logic              bit_valid,
  output logic [F-1:0]      word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic              overflow,
  input  logic              clear_ovf,
  output logic [FILL_W-1:0] fill
);

  generate
    if (F == 0) begin : g_bad_f
      $error("serial_word_packer: F must be at least 1");
    end
    if (MSB_FIRST > 1) begin : g_bad_msb_first
      $error("serial_word_packer: MSB_FIRST must be 0 or 1");
    end
  endgenerate

  // Counter value carried by the completing bit. For F=1 this is 0, so every
  // accepted bit completes a word and the counter never leaves 0.
  localparam logic [FILL_W-1:0] CNT_LAST = FILL_W'(F - 1);

  logic [F-1:0]      sr_q, sr_d;
  logic [FILL_W-1:0] cnt_q, cnt_d;
  logic [F-1:0]      word_q, word_d;
  logic              ovf_q, ovf_d;
  out_state_e        state_q, state_d;

  logic [F-1:0]      sr_merged;
  logic [31:0]       slot;
  logic              done;
  logic              drain;
  logic              load_word;
  logic              drop_word;

  // ---------------------------------------------------------------------------
  // Bit assembly
  // ---------------------------------------------------------------------------
  assign slot = slot_of(32'(cnt_q), 32'(F), MSB_FIRST != 0);
  assign done = bit_valid && (cnt_q == CNT_LAST);

  // Shift register with the incoming bit already written into its slot; on a
  // completing edge this is the finished word handed to the output register.
  always_comb begin
    sr_merged = sr_q;
    for (int unsigned i = 0; i < F; i++) begin
      if (32'(i) == slot) begin
        sr_merged[i] = bit_in;
      end
    end
  end

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (bit_valid) begin
      sr_d  = sr_merged;
      cnt_d = done ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sr_q  <= '0;
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output holding register FSM
  // ---------------------------------------------------------------------------
  // word_ready only matters once a word is held; while EMPTY it is ignored.
  assign drain = (state_q == OUT_FULL) && word_ready;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= OUT_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      OUT_EMPTY: begin
        if (done) begin
          state_d = OUT_FULL;
        end
      end
      OUT_FULL: begin
        // A drain coinciding with a new word keeps FULL: back-to-back, no bubble.
        if (drain && !done) begin
          state_d = OUT_EMPTY;
        end
      end
      default: state_d = OUT_EMPTY;
    endcase
  end

  // Output/control decode
  always_comb begin
    load_word = 1'b0;
    drop_word = 1'b0;
    unique case (state_q)
      OUT_EMPTY: load_word = done;
      OUT_FULL: begin
        load_word = done && drain;
        drop_word = done && !drain;
      end
      default: begin
        load_word = 1'b0;
        drop_word = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Word and overflow registers
  // ---------------------------------------------------------------------------
  // A dropped word never touches word_q, so word_out stays stable while blocked.
  assign word_d = load_word ? sr_merged : word_q;

  // A drop on the same edge as clear_ovf wins, so no dropped word goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (drop_word) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      word_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      ovf_q  <= ovf_d;
    end
  end

  assign word_out   = word_q;
  assign word_valid = (state_q == OUT_FULL);
  assign overflow   = ovf_q;
  assign fill       = cnt_q;

endmodule
